// File: rtl/dcache_ctrl_if.sv
// CPU MEM-stage and line-memory signal bundle for dcache_ctrl.
// The slave modport is the cache; the master modport is the pipeline/memory side.
interface dcache_ctrl_if #(
  parameter int LINE_W = 256
);
  logic              req_i;
  logic              we_i;
  logic [31:0]       addr_i;
  logic [31:0]       wdata_i;
  logic [31:0]       rdata_o;
  logic              stall_o;
  logic              mem_req_o;
  logic              mem_we_o;
  logic [31:0]       mem_addr_o;
  logic [LINE_W-1:0] mem_wdata_o;
  logic [LINE_W-1:0] mem_rdata_i;
  logic              mem_ack_i;

  modport slave (
    input  req_i, we_i, addr_i, wdata_i, mem_rdata_i, mem_ack_i,
    output rdata_o, stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output req_i, we_i, addr_i, wdata_i, mem_rdata_i, mem_ack_i,
    input  rdata_o, stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate data cache with miss stall FSM.
// Optional hit/miss counters are enabled by defining DCACHE_STATS_EN.
module dcache_ctrl #(
  parameter int SETS   = 32,
  parameter int LINE_W = 256
) (
  input  logic         clk_i,
  input  logic         rst_i,
  dcache_ctrl_if.slave bus
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]  hit_cnt_o,
  output logic [31:0]  miss_cnt_o
`endif
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 32 - 5 - IDX_W;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WRITEBACK   = 2'd1,
    ALLOCATE    = 2'd2,
    REFILL_DONE = 2'd3
  } state_e;

  function automatic logic [31:0] word_get(input logic [LINE_W-1:0] line,
                                           input logic [2:0]        sel);
    return line[{sel, 5'd0} +: 32];
  endfunction

  function automatic logic [LINE_W-1:0] word_put(input logic [LINE_W-1:0] line,
                                                 input logic [2:0]        sel,
                                                 input logic [31:0]       w);
    logic [LINE_W-1:0] l;
    l = line;
    l[{sel, 5'd0} +: 32] = w;
    return l;
  endfunction

  state_e            state_q, state_d;
  logic [SETS-1:0]   valid_q, valid_d;
  logic [SETS-1:0]   dirty_q, dirty_d;
  logic [TAG_W-1:0]  tag_q  [SETS];
  logic [LINE_W-1:0] data_q [SETS];

  logic [LINE_W-1:0] line_d;
  logic              line_we_s;
  logic              tag_we_s;

  logic [TAG_W-1:0]  req_tag_s;
  logic [IDX_W-1:0]  idx_s;
  logic [2:0]        word_s;
  logic [LINE_W-1:0] cur_line_s;
  logic [TAG_W-1:0]  cur_tag_s;
  logic              hit_s;
  logic              stall_s;
  logic [31:0]       rdata_s;
  logic              mem_req_s;
  logic              mem_we_s;
  logic [31:0]       mem_addr_s;
  logic [LINE_W-1:0] mem_wdata_s;
  logic              unused_s;

  assign req_tag_s  = bus.addr_i[31 -: TAG_W];
  assign idx_s      = bus.addr_i[5 +: IDX_W];
  assign word_s     = bus.addr_i[4:2];
  assign cur_line_s = data_q[idx_s];
  assign cur_tag_s  = tag_q[idx_s];
  assign unused_s   = ^bus.addr_i[1:0];

  assign hit_s   = bus.req_i & valid_q[idx_s] & (cur_tag_s == req_tag_s);
  assign stall_s = bus.req_i & ~((state_q == IDLE) & hit_s);

  // Next state, array update requests and memory-side outputs
  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    dirty_d     = dirty_q;
    line_d      = cur_line_s;
    line_we_s   = 1'b0;
    tag_we_s    = 1'b0;
    rdata_s     = 32'd0;
    mem_req_s   = 1'b0;
    mem_we_s    = 1'b0;
    mem_addr_s  = 32'd0;
    mem_wdata_s = {LINE_W{1'b0}};
    case (state_q)
      IDLE: begin
        if (hit_s) begin
          if (bus.we_i) begin
            line_d         = word_put(cur_line_s, word_s, bus.wdata_i);
            line_we_s      = 1'b1;
            dirty_d[idx_s] = 1'b1;
          end else begin
            rdata_s = word_get(cur_line_s, word_s);
          end
        end else if (bus.req_i) begin
          if (valid_q[idx_s] && dirty_q[idx_s]) begin
            state_d = WRITEBACK;
          end else begin
            state_d = ALLOCATE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WRITEBACK: begin
        mem_req_s   = 1'b1;
        mem_we_s    = 1'b1;
        mem_addr_s  = {cur_tag_s, idx_s, 5'd0};
        mem_wdata_s = cur_line_s;
        if (bus.mem_ack_i) begin
          state_d = ALLOCATE;
        end else begin
          state_d = WRITEBACK;
        end
      end
      ALLOCATE: begin
        mem_req_s  = 1'b1;
        mem_addr_s = {bus.addr_i[31:5], 5'd0};
        if (bus.mem_ack_i) begin
          line_d         = bus.mem_rdata_i;
          line_we_s      = 1'b1;
          tag_we_s       = 1'b1;
          valid_d[idx_s] = 1'b1;
          dirty_d[idx_s] = 1'b0;
          state_d        = REFILL_DONE;
        end else begin
          state_d = ALLOCATE;
        end
      end
      REFILL_DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control state: reset aborts any miss and invalidates every line
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      valid_q <= {SETS{1'b0}};
      dirty_q <= {SETS{1'b0}};
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // Tag and data arrays carry no reset; valid bits qualify them
  always_ff @(posedge clk_i) begin
    if (line_we_s) begin
      data_q[idx_s] <= line_d;
    end
    if (tag_we_s) begin
      tag_q[idx_s] <= req_tag_s;
    end
  end

  assign bus.rdata_o     = rdata_s;
  assign bus.stall_o     = stall_s;
  assign bus.mem_req_o   = mem_req_s;
  assign bus.mem_we_o    = mem_we_s;
  assign bus.mem_addr_o  = mem_addr_s;
  assign bus.mem_wdata_o = mem_wdata_s;

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  // Counters follow the IDLE hit/miss decision and wrap naturally
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if ((state_q == IDLE) && bus.req_i) begin
      if (hit_s) begin
        hit_cnt_d = hit_cnt_q + 32'd1;
      end else begin
        miss_cnt_d = miss_cnt_q + 32'd1;
      end
    end else begin
      hit_cnt_d = hit_cnt_q;
    end
  end

  // Statistics registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      hit_cnt_q  <= 32'd0;
      miss_cnt_q <= 32'd0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`endif

endmodule
